// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter sizing for the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sa_state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational full adder from two half adders plus an OR
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, c1, c2;
  assign s1 = a ^ b;
  assign c1 = a & b;
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;
endmodule

// File: rtl/serial_adder_fsm.sv
// serial_adder_fsm: LSB-first bit-serial adder with valid/ready operand and result handshakes
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output.
module serial_adder_fsm
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  sa_state_t        state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             carry, s, co, last;
  serial_fa_cell u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(s), .co(co));
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;
  assign last     = cnt == CW'(WIDTH - 1);
  // sum doubles as the result shift register; it only moves during SHIFT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      sum       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= cin;
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          sum   <= {s, sum[WIDTH-1:1]};
          carry <= co;
          cnt   <= last ? cnt : cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= co;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= carry ^ co;
`endif
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb_serial_adder_fsm: directed self-checking bench for serial_adder_fsm (WIDTH=8)
module tb_serial_adder_fsm;
  logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, cin = 0;
  logic [7:0] a = 0, b = 0, sum;
  logic       in_ready, out_valid, cout, busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif
  int checks = 0, failures = 0;

  serial_adder_fsm #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    a = va; b = vb; cin = vc; in_valid = 1;
    check("op_in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (lat == 0) begin
        if (out_valid) lat = i - 1;
        else tick();
      end
    end
    if (lat == 0 && out_valid) lat = 20;
    check("op_latency", lat, 8);
    check("op_sum", sum, es);
    check("op_cout", cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
    check("op_ovf", ovf, eo);
`endif
    out_ready = 1;
    tick();
    out_ready = 0;
    check("op_release_valid", out_valid, 0);
    check("op_release_ready", in_ready, 1);
  endtask

  logic [7:0] vec_a [4] = '{8'h12, 8'hAA, 8'h80, 8'hC3};
  logic [7:0] vec_b [4] = '{8'h34, 8'h55, 8'h7F, 8'h3C};
  logic       vec_c [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] vec_s [4] = '{8'h46, 8'h00, 8'hFF, 8'h00};
  logic       vec_co[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [7:0] held;
    logic       stable, saw_valid, prev_ready;
    int         ia, ir, last_t;
    #2;
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1;
    tick();

    run_op(8'h0F, 8'h01, 0, 8'h10, 0, 0);
    run_op(8'hFF, 8'h01, 0, 8'h00, 1, 0);
    run_op(8'hFF, 8'hFF, 1, 8'hFF, 1, 0);
    run_op(8'h7F, 8'h01, 0, 8'h80, 0, 1);
    run_op(8'h80, 8'h80, 0, 8'h00, 1, 1);
    run_op(8'h01, 8'h01, 0, 8'h02, 0, 0);

    // stall in DONE while a new operand is offered
    a = 8'h21; b = 8'h43; cin = 0; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 8; i++) tick();
    check("stall_entry_valid", out_valid, 1);
    held = sum;
    check("stall_sum", held, 8'h64);
    stable = 1;
    a = 8'hEE; b = 8'h11; in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sum !== held || out_valid !== 1 || in_ready !== 0 || busy !== 1) stable = 0;
    end
    check("stall_stable", stable, 1);
    in_valid = 0; out_ready = 1;
    tick();
    out_ready = 0;
    check("stall_exit_ready", in_ready, 1);
    check("stall_exit_valid", out_valid, 0);
    check("stall_exit_busy", busy, 0);

    // reset mid-operation at cnt=3
    a = 8'hF0; b = 8'h0F; cin = 1; in_valid = 1;
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    check("mid_busy_before", busy, 1);
    rst_n = 0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_sum", sum, 0);
    saw_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) saw_valid = 1;
    end
    check("mid_rst_no_valid", saw_valid, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
    run_op(8'h05, 8'h03, 0, 8'h08, 0, 0);

    // back-to-back with in_valid and out_ready tied high
    ia = 0; ir = 0; last_t = -1;
    a = vec_a[0]; b = vec_b[0]; cin = vec_c[0];
    in_valid = 1; out_ready = 1;
    prev_ready = in_ready;
    for (int t = 0; t < 100 && ir < 4; t++) begin
      tick();
      if (prev_ready && ia < 4) begin
        ia++;
        if (ia < 4) begin a = vec_a[ia]; b = vec_b[ia]; cin = vec_c[ia]; end
      end
      if (out_valid) begin
        check("b2b_sum", sum, vec_s[ir]);
        check("b2b_cout", cout, vec_co[ir]);
        if (last_t >= 0) check("b2b_interval", t - last_t, 10);
        last_t = t;
        ir++;
      end
      prev_ready = in_ready;
    end
    check("b2b_results", ir, 4);
    in_valid = 0; out_ready = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
